fu_wb_arbiter: RTL and testbench
================================

Name: fu_wb_arbiter

Overview:
- Writeback stage downstream of the multi-cycle functional units (ALU, mem, mul, div, jump) in the scoreboard core.
- Each FU raises a one-cycle `finish` pulse with its result. The block latches each result into a per-FU holding slot.
- Grants one slot per cycle to the single register-file write port.
- Reports the completed FU to the scoreboard so it can release the FU and clear hazards.

Parameters:
- NUM_FU, 5, number of functional units (slot index 0..NUM_FU-1); legal range 2..8
- DATA_W, 32, result width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- fu_finish  input  NUM_FU  bit i: one-cycle completion pulse from FU i
- fu_data  input  NUM_FU*DATA_W  FU i result at bits [i*DATA_W +: DATA_W]
- fu_rd  input  NUM_FU*5  destination register of FU i, driven by the scoreboard, valid with fu_finish[i]
- slot_pending  output  NUM_FU  bit i: slot i holds an unretired result; scoreboard must not issue to FU i while set
- wb_valid  output  1  a result is retiring this cycle
- wb_we  output  1  register-file write enable = wb_valid & (wb_rd != 0)
- wb_rd  output  5  destination register
- wb_data  output  DATA_W  result
- wb_fu  output  NUM_FU  one-hot id of the retiring FU (all zero when wb_valid=0)
- overflow  output  1  sticky error flag

Behaviour:
- Reset (async, immediate):
  - slot_pending=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_fu=0, overflow=0.
  - Round-robin pointer=0.
  - Any results in flight are discarded.
- Capture: at the rising edge where fu_finish[i]=1, slot i stores fu_data and fu_rd and sets pending[i]. Capture is edge-registered; the pending bit is visible the next cycle.
- Arbitration (combinational on registered pending):
  - Select one pending slot per the priority rule.
  - At the next edge, the wb_* registers load the selected slot and pending for that slot clears.
  - If no slot is pending, wb_valid=0 and wb_fu=0 at that edge.
- Latency: finish high in cycle t, no contention → wb_valid high in cycle t+2 for exactly one cycle.
- Throughput: one retirement per cycle. Slots are held indefinitely until granted; no result is dropped except on overflow.
- Same slot granted and re-finished at the same edge: the grant retires the old contents and the new finish is captured; pending[i] stays 1.
- fu_finish[i]=1 while pending[i]=1 and slot i is not granted at that edge:
  - overflow is set (sticky until rst).
  - The new data overwrites the slot.
  - Only one retirement occurs.
- rd=0 results:
  - retire normally, with wb_valid=1, wb_fu set and wb_we=0.
  - They still consume a grant.
- Multiple simultaneous finishes are all captured at the same edge, then drained over successive cycles.
- wb_data and wb_rd hold their last values when wb_valid=0.

Optional Feature:
- Macro: WB_RR_EN.
- Defined: round-robin priority.
  - The search starts at pointer p and wraps modulo NUM_FU.
  - After a grant to slot k, p ← (k+1) mod NUM_FU; the pointer is unchanged when there is no grant.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.

Test Plan:
- Single FU:
  - Stimulus: reset, then fu_finish=5'b00010, data1=0x0000_1234, rd1=7 in cycle 3.
  - Response: cycle 5 shows wb_valid=1, wb_we=1, wb_rd=7, wb_data=0x1234, wb_fu=5'b00010; slot_pending[1]=1 during cycle 4 only.
- Simultaneous finish, fixed priority (WB_RR_EN undefined):
  - Stimulus: FU0 (rd=1, 0xA), FU2 (rd=3, 0xC), FU4 (rd=5, 0xE) all finish in cycle 3.
  - Response: retire FU0, FU2, FU4 in cycles 5, 6, 7; wb_valid=0 in cycle 8.
- Round robin (WB_RR_EN defined):
  - Stimulus: FU0 and FU1 each refinish every cycle their slot retires, starting cycle 3.
  - Response: wb_fu alternates 00001, 00010, 00001, … with no starvation over 20 cycles.
- rd=0:
  - Stimulus: FU3 finishes with rd=0, data=0xFFFF_FFFF.
  - Response: two cycles later wb_valid=1, wb_we=0, wb_fu=5'b01000.
- Overflow:
  - Stimulus: FU4 finishes (data 0x11) while FU0 and FU1 are pending and win priority, then FU4 finishes again (data 0x22) before slot 4 is granted.
  - Response: overflow=1 and stays 1; slot 4 retires once with 0x22.
- Reset mid-operation:
  - Stimulus: three slots pending, assert rst asynchronously mid-cycle.
  - Response: slot_pending=0 and wb_valid=0 immediately; no retirement after rst deasserts until a new fu_finish.

Source files
------------

// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: writeback arbiter behind the multi-cycle functional units.
// Each FU finish pulse is latched into a per-FU holding slot; one slot per
// cycle is granted to the single register-file write port.
// Build option: define WB_RR_EN for round-robin priority; otherwise the
// lowest pending slot index wins and no pointer register is built.
module fu_wb_arbiter #(
  parameter int unsigned NUM_FU = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        fu_finish,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  input  logic [NUM_FU*5-1:0]      fu_rd,
  output logic [NUM_FU-1:0]        slot_pending,
  output logic                     wb_valid,
  output logic                     wb_we,
  output logic [4:0]               wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic [NUM_FU-1:0]        wb_fu,
  output logic                     overflow
);

  localparam int unsigned PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] r_pending;
  logic [DATA_W-1:0] r_data [NUM_FU];
  logic [4:0]        r_rd   [NUM_FU];
  logic              r_ovf;
  logic              r_wb_valid;
  logic              r_wb_we;
  logic [4:0]        r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [NUM_FU-1:0] r_wb_fu;

  logic              w_any;
  logic [PW-1:0]     w_sel;
  logic [NUM_FU-1:0] w_grant;

`ifdef WB_RR_EN
  logic [PW-1:0]     r_ptr;
  logic [PW:0]       w_idx;

  // Round-robin select: first pending slot at or after the pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(off);
      if (w_idx >= (PW+1)'(NUM_FU))
        w_idx = w_idx - (PW+1)'(NUM_FU);
      if (!w_any && r_pending[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[PW-1:0];
      end
    end
  end

  // Pointer moves just past the granted slot; holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (w_any)
      r_ptr <= (w_sel == PW'(NUM_FU-1)) ? '0 : w_sel + PW'(1);
  end
`else
  // Fixed-priority select: lowest pending slot index wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (!w_any && r_pending[i]) begin
        w_any = 1'b1;
        w_sel = PW'(i);
      end
    end
  end
`endif

  // One-hot form of the selected slot, empty when nothing is pending.
  always_comb begin
    w_grant = '0;
    if (w_any)
      w_grant = NUM_FU'(1) << w_sel;
  end

  // Slot capture: a finish always wins over a same-edge grant, so a granted
  // slot that refinishes stays pending; refinish of an ungranted slot is an overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        r_data[i] <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      r_pending <= fu_finish | (r_pending & ~w_grant);
      if (|(fu_finish & r_pending & ~w_grant))
        r_ovf <= 1'b1;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (fu_finish[i]) begin
          r_data[i] <= fu_data[i*DATA_W +: DATA_W];
          r_rd[i]   <= fu_rd[i*5 +: 5];
        end
      end
    end
  end

  // Writeback register: loads the granted slot; rd/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_fu    <= '0;
    end else begin
      r_wb_valid <= w_any;
      r_wb_fu    <= w_grant;
      r_wb_we    <= w_any && (r_rd[w_sel] != 5'd0);
      if (w_any) begin
        r_wb_rd   <= r_rd[w_sel];
        r_wb_data <= r_data[w_sel];
      end
    end
  end

  assign slot_pending = r_pending;
  assign wb_valid     = r_wb_valid;
  assign wb_we        = r_wb_we;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign wb_fu        = r_wb_fu;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Testbench for fu_wb_arbiter: expected retirements are queued when finishes
// are driven and popped by a monitor whenever wb_valid is seen.
module tb_fu_wb_arbiter;

  localparam int unsigned NF = 5;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [NF-1:0] fu;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NF-1:0]    fu_finish = '0;
  logic [NF*DW-1:0] fu_data = '0;
  logic [NF*5-1:0]  fu_rd = '0;
  logic [NF-1:0]    slot_pending;
  logic             wb_valid;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [DW-1:0]    wb_data;
  logic [NF-1:0]    wb_fu;
  logic             overflow;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fu_wb_arbiter #(.NUM_FU(NF), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .fu_finish(fu_finish), .fu_data(fu_data), .fu_rd(fu_rd),
    .slot_pending(slot_pending), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_fu(wb_fu), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every retirement must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_retire act fu=%b rd=%0d data=%h req none", wb_fu, wb_rd, wb_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (wb_fu !== e.fu || wb_rd !== e.rd || wb_data !== e.data || wb_we !== (e.rd != 5'd0))
            $display("FAIL retire act fu=%b rd=%0d data=%h we=%b req fu=%b rd=%0d data=%h we=%b",
                     wb_fu, wb_rd, wb_data, wb_we, e.fu, e.rd, e.data, (e.rd != 5'd0));
          else
            n_pass++;
        end
      end else begin
        n_checks++;
        if (wb_fu !== '0 || wb_we !== 1'b0)
          $display("FAIL idle_outputs act fu=%b we=%b req fu=0 we=0", wb_fu, wb_we);
        else
          n_pass++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
    fu_finish = '0;
  endtask

  task automatic drive(input int unsigned i, input logic [4:0] rd, input logic [DW-1:0] d, input bit push);
    exp_t e;
    fu_finish[i]        = 1'b1;
    fu_data[i*DW +: DW] = d;
    fu_rd[i*5 +: 5]     = rd;
    if (push) begin
      e.fu   = NF'(1) << i;
      e.rd   = rd;
      e.data = d;
      q.push_back(e);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    fu_finish = '0;
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if (slot_pending !== '0 || wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== '0 ||
        wb_data !== '0 || wb_fu !== '0 || overflow !== 1'b0)
      $display("FAIL reset_state act pend=%b v=%b we=%b rd=%0d data=%h fu=%b ovf=%b req all zero",
               slot_pending, wb_valid, wb_we, wb_rd, wb_data, wb_fu, overflow);
    else
      n_pass++;
    do_reset;
  endtask

  task automatic test_single;
    do_reset;
    step; step;
    drive(1, 5'd7, 32'h0000_1234, 1'b1);
    @(negedge clk);
    n_checks++;
    if (slot_pending !== 5'b00000) $display("FAIL single_pend_t act=%b req=00000", slot_pending); else n_pass++;
    step;
    @(negedge clk);
    n_checks++;
    if (slot_pending !== 5'b00010 || wb_valid !== 1'b0)
      $display("FAIL single_pend_t1 act pend=%b v=%b req pend=00010 v=0", slot_pending, wb_valid);
    else n_pass++;
    step;
    @(negedge clk);
    n_checks++;
    if (slot_pending !== 5'b00000 || wb_valid !== 1'b1 || wb_fu !== 5'b00010)
      $display("FAIL single_t2 act pend=%b v=%b fu=%b req pend=00000 v=1 fu=00010", slot_pending, wb_valid, wb_fu);
    else n_pass++;
    step;
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd7 || wb_data !== 32'h1234)
      $display("FAIL single_hold act v=%b rd=%0d data=%h req v=0 rd=7 data=00001234", wb_valid, wb_rd, wb_data);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    logic [NF-1:0] exp_fu [3];
    logic [NF-1:0] exp_pd [3];
    exp_fu = '{5'b00001, 5'b00100, 5'b10000};
    exp_pd = '{5'b10100, 5'b10000, 5'b00000};
    do_reset;
    step;
    drive(0, 5'd1, 32'hA, 1'b1);
    drive(2, 5'd3, 32'hC, 1'b1);
    drive(4, 5'd5, 32'hE, 1'b1);
    step;
    @(negedge clk);
    n_checks++;
    if (slot_pending !== 5'b10101) $display("FAIL simul_pend act=%b req=10101", slot_pending); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step;
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_fu !== exp_fu[k] || slot_pending !== exp_pd[k])
        $display("FAIL simul_drain%0d act v=%b fu=%b pend=%b req v=1 fu=%b pend=%b",
                 k, wb_valid, wb_fu, slot_pending, exp_fu[k], exp_pd[k]);
      else n_pass++;
    end
    step;
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) $display("FAIL simul_end act v=%b req v=0", wb_valid); else n_pass++;
  endtask

  task automatic test_rd0;
    do_reset;
    step;
    drive(3, 5'd0, 32'hFFFF_FFFF, 1'b1);
    step; step;
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_fu !== 5'b01000)
      $display("FAIL rd0 act v=%b we=%b fu=%b req v=1 we=0 fu=01000", wb_valid, wb_we, wb_fu);
    else n_pass++;
    step;
  endtask

  task automatic test_back_to_back;
    do_reset;
    step;
    drive(2, 5'd9, 32'h5, 1'b1);
    step;
    drive(2, 5'd10, 32'h6, 1'b1);
    @(negedge clk);
    n_checks++;
    if (slot_pending !== 5'b00100) $display("FAIL b2b_pend0 act=%b req=00100", slot_pending); else n_pass++;
    step;
    @(negedge clk);
    n_checks++;
    if (slot_pending !== 5'b00100 || wb_fu !== 5'b00100)
      $display("FAIL b2b_pend1 act pend=%b fu=%b req pend=00100 fu=00100", slot_pending, wb_fu);
    else n_pass++;
    step;
    @(negedge clk);
    n_checks++;
    if (slot_pending !== 5'b00000 || wb_valid !== 1'b1 || overflow !== 1'b0)
      $display("FAIL b2b_second act pend=%b v=%b ovf=%b req pend=00000 v=1 ovf=0", slot_pending, wb_valid, overflow);
    else n_pass++;
    step;
  endtask

  task automatic test_overflow;
    do_reset;
    step;
    drive(0, 5'd1, 32'hA0, 1'b1);
    drive(1, 5'd2, 32'hB0, 1'b1);
    drive(4, 5'd3, 32'h11, 1'b0);
    step;
    drive(4, 5'd3, 32'h22, 1'b1);
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_before act=%b req=0", overflow); else n_pass++;
    step;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1 || slot_pending !== 5'b10010)
      $display("FAIL ovf_set act ovf=%b pend=%b req ovf=1 pend=10010", overflow, slot_pending);
    else n_pass++;
    for (int k = 0; k < 5; k++) step;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1 || slot_pending !== 5'b00000)
      $display("FAIL ovf_sticky act ovf=%b pend=%b req ovf=1 pend=00000", overflow, slot_pending);
    else n_pass++;
  endtask

`ifdef WB_RR_EN
  task automatic test_priority;
    do_reset;
    step;
    drive(0, 5'd4, 32'h100, 1'b1);
    drive(1, 5'd6, 32'h101, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step;
      drive((k % 2 == 1) ? 0 : 1, 5'd4 + 5'((k + 1) % 2) * 5'd2, 32'h100 + 32'(k + 1), 1'b1);
      if (k >= 2) begin
        @(negedge clk);
        n_checks++;
        if (slot_pending !== 5'b00011) $display("FAIL rr_pend%0d act=%b req=00011", k, slot_pending); else n_pass++;
      end
    end
    for (int k = 0; k < 4; k++) step;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0 || q.size() != 0)
      $display("FAIL rr_end act ovf=%b left=%0d req ovf=0 left=0", overflow, q.size());
    else n_pass++;
  endtask
`else
  task automatic test_priority;
    exp_t e;
    do_reset;
    step;
    drive(0, 5'd4, 32'h200, 1'b1);
    drive(1, 5'd6, 32'h201, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step;
      drive(0, 5'd4, 32'h210 + 32'(k), 1'b1);
      @(negedge clk);
      n_checks++;
      if (slot_pending !== 5'b00011) $display("FAIL fixed_pend%0d act=%b req=00011", k, slot_pending); else n_pass++;
    end
    e.fu = 5'b00010; e.rd = 5'd6; e.data = 32'h201;
    q.push_back(e);
    for (int k = 0; k < 5; k++) step;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0 || q.size() != 0)
      $display("FAIL fixed_end act ovf=%b left=%0d req ovf=0 left=0", overflow, q.size());
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid;
    do_reset;
    step;
    drive(0, 5'd1, 32'h1, 1'b1);
    drive(1, 5'd2, 32'h2, 1'b1);
    drive(2, 5'd3, 32'h3, 1'b1);
    step;
    step;
    @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    n_checks++;
    if (slot_pending !== '0 || wb_valid !== 1'b0 || wb_fu !== '0)
      $display("FAIL reset_mid act pend=%b v=%b fu=%b req all zero", slot_pending, wb_valid, wb_fu);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step;
    @(negedge clk);
    n_checks++;
    if (slot_pending !== '0 || q.size() != 0)
      $display("FAIL reset_after act pend=%b left=%0d req pend=0 left=0", slot_pending, q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_rd0;
    test_back_to_back;
    test_overflow;
    test_priority;
    test_reset_mid;
    step;
    n_checks++;
    if (q.size() != 0) $display("FAIL final_queue act=%0d req=0", q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
